fetch_decode_queue: RTL and testbench



---
 rtl/pipe_pkg.sv | 15 +
 rtl/fetch_decode_queue.sv | 133 +++++++++++++
 tb/tb_fetch_decode_queue.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the fetch/decode boundary.
package pipe_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int EXC_W_DEFAULT = 8;

  localparam logic [EXC_W_DEFAULT-1:0] EXC_NONE = 8'h00;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0]  pc;
    logic [XLEN_DEFAULT-1:0]  instr;
    logic [EXC_W_DEFAULT-1:0] exc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// Instruction FIFO between fetch and decode with optional consecutive-duplicate filter.
// One-cycle enqueue latency, async head read; in_ready is registered low at full, independent of deq.
module fetch_decode_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int EXC_W    = EXC_W_DEFAULT,
  parameter int DEDUP    = 1,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic                       halt,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  input  logic [EXC_W-1:0]           in_exc,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic [EXC_W-1:0]           out_exc,
  input  logic                       deq,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       dup_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [EXC_W-1:0] exc;
  } entry_t;

  // Plain register file: the head is read asynchronously, so this must stay in flops.
  entry_t mem_q [DEPTH];

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            last_valid_q, last_valid_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d, last_instr_q, last_instr_d;
  logic            dup_drop_q, dup_drop_d;
  logic            in_ready_q, in_ready_d;
  logic            af_q, af_d;
  logic            upd, dup_hit, enq_ok, deq_ok, wr_en;

  assign upd     = clk_en && !halt;
  // Words carrying an exception are never filtered.
  assign dup_hit = (DEDUP != 0) && last_valid_q && (in_exc == '0)
                   && (in_pc == last_pc_q) && (in_instr == last_instr_q);
  assign enq_ok  = in_valid && in_ready_q && !dup_hit;
  assign deq_ok  = deq && out_valid;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    last_valid_d = last_valid_q;
    last_pc_d    = last_pc_q;
    last_instr_d = last_instr_q;
    dup_drop_d   = 1'b0;
    wr_en        = 1'b0;
    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      last_valid_d = 1'b0;
    end else begin
      if (enq_ok) begin
        wr_en        = 1'b1;
        wr_ptr_d     = wr_ptr_q + PW'(1);
        last_pc_d    = in_pc;
        last_instr_d = in_instr;
        last_valid_d = (in_exc == '0);
      end
      if (deq_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d    = count_q + CW'(enq_ok) - CW'(deq_ok);
      dup_drop_d = in_valid && in_ready_q && dup_hit;
    end
    in_ready_d = (count_d != FULL_CNT);
    af_d       = (count_d >= AF_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      last_valid_q <= 1'b0;
      last_pc_q    <= '0;
      last_instr_q <= '0;
      dup_drop_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      af_q         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (upd) begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_valid_q <= last_valid_d;
      last_pc_q    <= last_pc_d;
      last_instr_q <= last_instr_d;
      dup_drop_q   <= dup_drop_d;
      in_ready_q   <= in_ready_d;
      af_q         <= af_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {in_pc, in_instr, in_exc};
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != '0);
  assign out_pc      = mem_q[rd_ptr_q].pc;
  assign out_instr   = mem_q[rd_ptr_q].instr;
  assign out_exc     = mem_q[rd_ptr_q].exc;
  assign count       = count_q;
  assign almost_full = af_q;
  assign dup_drop    = dup_drop_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench: a queue model predicts contents, a negedge monitor checks the head as decode consumes it.
module tb_fetch_decode_queue;
  import pipe_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        halt = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_exc = '0;
  logic        deq = 1'b0;

  logic        in_ready, out_valid, almost_full, dup_drop;
  logic [31:0] out_pc, out_instr;
  logic [7:0]  out_exc;
  logic [2:0]  count;

  logic        in_ready0, out_valid0, almost_full0, dup_drop0;
  logic [31:0] out_pc0, out_instr0;
  logic [7:0]  out_exc0;
  logic [2:0]  count0;

  fetch_decode_queue #(.DEPTH(DEPTH), .DEDUP(1)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_exc(in_exc), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_exc(out_exc), .deq(deq), .count(count), .almost_full(almost_full),
    .dup_drop(dup_drop)
  );

  fetch_decode_queue #(.DEPTH(DEPTH), .DEDUP(0)) dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_pc(in_pc), .in_instr(in_instr),
    .in_exc(in_exc), .out_valid(out_valid0), .out_pc(out_pc0), .out_instr(out_instr0),
    .out_exc(out_exc0), .deq(deq), .count(count0), .almost_full(almost_full0),
    .dup_drop(dup_drop0)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  fq_entry_t   exp_q[$];
  logic        last_valid_m = 1'b0;
  logic [31:0] last_pc_m = '0;
  logic [31:0] last_ins_m = '0;
  logic        exp_drop = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: head must match the oldest expected entry; consumption pops it.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        chk("head_pc",    64'(out_pc),    64'(exp_q[0].pc));
        chk("head_instr", 64'(out_instr), 64'(exp_q[0].instr));
        chk("head_exc",   64'(out_exc),   64'(exp_q[0].exc));
        if (deq && clk_en && !halt) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_status();
    chk("count",       64'(count),       64'(exp_q.size()));
    chk("in_ready",    64'(in_ready),    64'(exp_q.size() < DEPTH));
    chk("almost_full", 64'(almost_full), 64'(exp_q.size() >= DEPTH - 1));
    chk("dup_drop",    64'(dup_drop),    64'(exp_drop));
  endtask

  // Called just after a posedge; drives one cycle and advances the model across the next edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [7:0] ex, input logic d, input logic fl,
                      input logic h, input logic ce);
    logic upd, rdy, hit, enq;
    in_valid = v; in_pc = pc; in_instr = ins; in_exc = ex;
    deq = d; flush = fl; halt = h; clk_en = ce;
    upd = ce && !h;
    rdy = exp_q.size() < DEPTH;
    hit = last_valid_m && (ex == EXC_NONE) && pc == last_pc_m && ins == last_ins_m;
    enq = upd && !fl && v && rdy && !hit;
    @(posedge clk);
    if (upd) begin
      exp_drop = !fl && v && rdy && hit;
      if (fl) begin
        exp_q.delete();
        last_valid_m = 1'b0;
      end else if (enq) begin
        exp_q.push_back('{pc: pc, instr: ins, exc: ex});
        last_pc_m    = pc;
        last_ins_m   = ins;
        last_valid_m = (ex == EXC_NONE);
      end
    end
    #1;
    in_valid = 1'b0; deq = 1'b0; flush = 1'b0; halt = 1'b0; clk_en = 1'b1;
    check_status();
  endtask

  task automatic push(input logic [31:0] pc);
    step(1'b1, pc, pc ^ 32'hA5A5_0000, EXC_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop();
    step(1'b0, '0, '0, EXC_NONE, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    last_valid_m = 1'b0;
    exp_drop = 1'b0;
    chk("rst_count",     64'(count),       64'd0);
    chk("rst_in_ready",  64'(in_ready),    64'd1);
    chk("rst_af",        64'(almost_full), 64'd0);
    chk("rst_out_valid", 64'(out_valid),   64'd0);
    chk("rst_dup_drop",  64'(dup_drop),    64'd0);
    chk("rst_out_pc",    64'(out_pc),      64'd0);
    chk("rst_out_instr", 64'(out_instr),   64'd0);
    chk("rst_out_exc",   64'(out_exc),     64'd0);
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Fill to full, attempt overflow, drain in order.
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i));
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(in_ready), 64'd0);
    push(32'h110);
    for (int i = 0; i < 4; i++) pop();
    pop();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Wrap pointers several times.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) push(32'h400 + 32'(16 * r + 4 * i));
      for (int i = 0; i < 3; i++) pop();
    end
    chk("wrap_count", 64'(count), 64'd0);

    // Simultaneous enqueue and dequeue at count 2.
    push(32'h500); push(32'h504);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h508 + 32'(4 * i), 32'h1111_0000 + 32'(i), EXC_NONE, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("simul_count", 64'(count), 64'd2);
    pop(); pop();

    // Dedup: second identical word is filtered; the DEDUP=0 instance keeps both.
    do_reset();
    step(1'b1, 32'h200, 32'h0840_0001, EXC_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h200, 32'h0840_0001, EXC_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("dedup_count", 64'(count), 64'd1);
    chk("dedup_pulse", 64'(dup_drop), 64'd1);
    chk("nodedup_count", 64'(count0), 64'd2);
    chk("nodedup_valid", 64'(out_valid0), 64'd1);
    chk("nodedup_pc", 64'(out_pc0), 64'h200);
    chk("nodedup_instr", 64'(out_instr0), 64'h0840_0001);
    chk("nodedup_exc", 64'(out_exc0), 64'd0);
    chk("nodedup_ready", 64'(in_ready0), 64'd1);
    chk("nodedup_af", 64'(almost_full0), 64'd0);
    chk("nodedup_drop", 64'(dup_drop0), 64'd0);
    step(1'b0, '0, '0, EXC_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("dedup_pulse_end", 64'(dup_drop), 64'd0);

    // Same pair with an exception code is never filtered.
    step(1'b1, 32'h200, 32'h0840_0001, 8'h82, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("exc_count", 64'(count), 64'd2);
    chk("exc_nodrop", 64'(dup_drop), 64'd0);
    pop(); pop();

    // Flush with concurrent push.
    push(32'h600); push(32'h604); push(32'h608);
    step(1'b1, 32'h60C, 32'h0, EXC_NONE, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);

    // Halt and clock-enable low freeze state even with deq and push.
    push(32'h700); push(32'h704);
    step(1'b1, 32'h708, 32'h0, EXC_NONE, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("halt_count", 64'(count), 64'd2);
    step(1'b1, 32'h708, 32'h0, EXC_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ce_count", 64'(count), 64'd2);

    // Reset mid-fill.
    push(32'h800);
    do_reset();

    // Randomized traffic with a small PC pool so duplicates are frequent.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, pc, pc | 32'h0840_0000,
           ($urandom_range(0, 7) == 0) ? 8'h82 : EXC_NONE,
           $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 11) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
